// File: rtl/mux_operand_loader_pkg.sv
// rtl/mux_operand_loader_pkg.sv - shared constants for the operand mux loader
//
// Purpose: state encoding, select codes and default operand width shared by
// the loader RTL.
// Contents:
//   IDLE/LOAD/SCAN  - 2-bit FSM state codes
//   SEL_A..SEL_D    - s1s0 codes that present operands a..d on the mux
//   DEFAULT_WIDTH   - operand width of the downstream 4:1 mux
package mux_operand_loader_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux_operand_loader.sv
// rtl/mux_operand_loader.sv - packs four stream words into a..d and scans the mux selects
//
// Purpose: accepts four consecutive words over a valid/ready handshake into
// operand registers a..d, then steps s1s0 through 00..11 (paced by
// out_ready) PASSES times before returning to loading.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - synchronous abort back to an empty bank in LOAD
//   in_valid/in_ready/in_data - upstream word handshake
//   a, b, c, d            - operand bank driving the 4:1 mux data inputs
//   s0, s1                - mux select (s1 is the MSB)
//   out_valid/out_ready   - consumer handshake on the mux output
//   scan_done             - one-cycle pulse when the final step is accepted
module mux_operand_loader
  import mux_operand_loader_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int PASSES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             s0,
  output logic             s1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             scan_done
);

  // pass_cnt counts completed passes; the pass with this index is the final one
  localparam logic [3:0] LAST_PASS = 4'(PASSES - 1);

  logic [1:0] state;
  logic [1:0] load_ptr;
  logic [3:0] pass_cnt;
  logic [1:0] sel;

  assign s0 = sel[0];
  assign s1 = sel[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      sel       <= SEL_A;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      scan_done <= 1'b0;
      load_ptr  <= 2'd0;
      pass_cnt  <= 4'd0;
    end else begin
      scan_done <= 1'b0;
      if (flush) begin
        // any handshake in this cycle is dropped: no write, no select step
        state     <= LOAD;
        a         <= '0;
        b         <= '0;
        c         <= '0;
        d         <= '0;
        sel       <= SEL_A;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        load_ptr  <= 2'd0;
        pass_cnt  <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
          LOAD: begin
            if (in_valid && in_ready) begin
              case (load_ptr)
                2'd0:    a <= in_data;
                2'd1:    b <= in_data;
                2'd2:    c <= in_data;
                default: d <= in_data;
              endcase
              load_ptr <= load_ptr + 2'd1;
              if (load_ptr == 2'd3) begin
                // bank complete: present operand a in the very next cycle
                state     <= SCAN;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                sel       <= SEL_A;
                pass_cnt  <= 4'd0;
              end
            end
          end
          SCAN: begin
            if (out_valid && out_ready) begin
              case (sel)
                SEL_A: sel <= SEL_B;
                SEL_B: sel <= SEL_C;
                SEL_C: sel <= SEL_D;
                default: begin
                  sel <= SEL_A;
                  if (pass_cnt < LAST_PASS) begin
                    pass_cnt <= pass_cnt + 4'd1;
                  end else begin
                    // bank is kept; LOAD overwrites it word by word
                    scan_done <= 1'b1;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= LOAD;
                  end
                end
              endcase
            end
          end
          default: begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
